// File: rtl/stream_demux2.sv
// 1-to-2 valid/ready stream demultiplexer with a one-entry registered slot per output.
// Optional delivered-beat counters (cnt0/cnt1) are enabled by defining STREAM_DEMUX_CNT_EN.
module stream_demux2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
`ifdef STREAM_DEMUX_CNT_EN
   ,output logic [31:0]      cnt0,
    output logic [31:0]      cnt1
`endif
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    slot_e            slot0_q, slot0_d;
    slot_e            slot1_q, slot1_d;
    logic [WIDTH-1:0] data0_q, data0_d;
    logic [WIDTH-1:0] data1_q, data1_d;

    logic accept0;
    logic accept1;
    logic pop0;
    logic pop1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot0_q <= SLOT_EMPTY;
            slot1_q <= SLOT_EMPTY;
            data0_q <= '0;
            data1_q <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
        end
    end

    // A slot can take a new beat when empty or when its current beat leaves this cycle.
    always_comb begin
        pop0 = (slot0_q == SLOT_FULL) && out0_ready;
        pop1 = (slot1_q == SLOT_FULL) && out1_ready;
        if (in_sel) begin
            in_ready = (slot1_q == SLOT_EMPTY) || out1_ready;
        end else begin
            in_ready = (slot0_q == SLOT_EMPTY) || out0_ready;
        end
        accept0 = in_valid && in_ready && !in_sel;
        accept1 = in_valid && in_ready &&  in_sel;
    end

    // Accept wins over pop so a same-cycle pop+accept reloads without a bubble.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        data0_d = data0_q;
        data1_d = data1_q;
        if (accept0) begin
            slot0_d = SLOT_FULL;
            data0_d = in_data;
        end else if (pop0) begin
            slot0_d = SLOT_EMPTY;
        end
        if (accept1) begin
            slot1_d = SLOT_FULL;
            data1_d = in_data;
        end else if (pop1) begin
            slot1_d = SLOT_EMPTY;
        end
    end

    always_comb begin
        out0_valid = (slot0_q == SLOT_FULL);
        out1_valid = (slot1_q == SLOT_FULL);
        out0_data  = data0_q;
        out1_data  = data1_q;
    end

`ifdef STREAM_DEMUX_CNT_EN
    logic [31:0] cnt0_q, cnt0_d;
    logic [31:0] cnt1_q, cnt1_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    // Natural 32-bit wrap from all-ones back to zero.
    always_comb begin
        cnt0_d = pop0 ? cnt0_q + 32'd1 : cnt0_q;
        cnt1_d = pop1 ? cnt1_q + 32'd1 : cnt1_q;
        cnt0   = cnt0_q;
        cnt1   = cnt1_q;
    end
`endif

endmodule

// File: tb/tb_stream_demux2.sv
// Self-checking bench for stream_demux2: queue-based reference model plus directed vectors.
// Counter checks are compiled only when STREAM_DEMUX_CNT_EN is defined.
module tb_stream_demux2;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_sel = 1'b0;
    logic             out0_valid;
    logic             out0_ready = 1'b0;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready = 1'b0;
    logic [WIDTH-1:0] out1_data;
`ifdef STREAM_DEMUX_CNT_EN
    logic [31:0]      cnt0;
    logic [31:0]      cnt1;
`endif

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic [31:0]      modelCnt0 = '0;
    logic [31:0]      modelCnt1 = '0;

    stream_demux2 #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
`ifdef STREAM_DEMUX_CNT_EN
       ,.cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after the rising edge, well clear of both edges.
    task automatic applyStimulus(input logic v, input logic s, input logic [WIDTH-1:0] d,
                                 input logic r0, input logic r1);
        @(posedge clk);
        #2;
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    // Reference model: each output is a queue that may hold at most one beat.
    always @(posedge clk or negedge rstn) begin
        logic canTake;
        if (!rstn) begin
            q0.delete();
            q1.delete();
            modelCnt0 = '0;
            modelCnt1 = '0;
        end else begin
            canTake = in_sel ? (q1.size() == 0 || out1_ready) : (q0.size() == 0 || out0_ready);
            if (q0.size() > 0 && out0_ready) begin
                void'(q0.pop_front());
                modelCnt0 = modelCnt0 + 32'd1;
            end
            if (q1.size() > 0 && out1_ready) begin
                void'(q1.pop_front());
                modelCnt1 = modelCnt1 + 32'd1;
            end
            if (in_valid && canTake) begin
                if (in_sel) q1.push_back(in_data);
                else        q0.push_back(in_data);
            end
        end
    end

    // Mid-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        logic expReady;
        if (rstn) begin
            expReady = in_sel ? (q1.size() == 0 || out1_ready) : (q0.size() == 0 || out0_ready);
            checkOutput("model in_ready", {31'd0, in_ready}, {31'd0, expReady});
            checkOutput("model out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() > 0});
            checkOutput("model out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() > 0});
            if (q0.size() > 0) checkOutput("model out0_data", out0_data, q0[0]);
            if (q1.size() > 0) checkOutput("model out1_data", out1_data, q1[0]);
`ifdef STREAM_DEMUX_CNT_EN
            checkOutput("model cnt0", cnt0, modelCnt0);
            checkOutput("model cnt1", cnt1, modelCnt1);
`endif
        end
    end

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out0_valid", {31'd0, out0_valid}, 32'd0);
        checkOutput("reset out1_valid", {31'd0, out1_valid}, 32'd0);
        checkOutput("reset out0_data", out0_data, 32'd0);
        checkOutput("reset out1_data", out1_data, 32'd0);
        applyStimulus(0, 0, 0, 0, 0);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("post-reset in_ready", {31'd0, in_ready}, 32'd1);

        // Single beat into slot 1.
        applyStimulus(1, 1, 32'hDEADBEEF, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("single out1_valid", {31'd0, out1_valid}, 32'd1);
        checkOutput("single out1_data", out1_data, 32'hDEADBEEF);
        checkOutput("single out0_valid", {31'd0, out0_valid}, 32'd0);

        // Back-pressure on slot 1 while slot 0 stays free.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 32'h55, 0, 0);
            @(negedge clk);
            checkOutput("backpressure in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("backpressure out1_data", out1_data, 32'hDEADBEEF);
        end
        applyStimulus(1, 0, 32'h11, 0, 0);
        @(negedge clk);
        checkOutput("other slot in_ready", {31'd0, in_ready}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("other slot out0_data", out0_data, 32'h11);
        checkOutput("other slot out0_valid", {31'd0, out0_valid}, 32'd1);
        checkOutput("held out1_data", out1_data, 32'hDEADBEEF);

        // Both consumers pop in the same cycle.
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("dual pop out0_valid", {31'd0, out0_valid}, 32'd0);
        checkOutput("dual pop out1_valid", {31'd0, out1_valid}, 32'd0);

        // Back-to-back streaming into slot 0.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, WIDTH'(i), 1, 0);
            @(negedge clk);
            checkOutput("stream in_ready", {31'd0, in_ready}, 32'd1);
            if (i > 0) checkOutput("stream out0_data", out0_data, 32'(i - 1));
        end
        applyStimulus(0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("stream last out0_data", out0_data, 32'd7);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("stream drained", {31'd0, out0_valid}, 32'd0);

        // Simultaneous pop and accept on slot 0.
        applyStimulus(1, 0, 32'hA, 0, 0);
        applyStimulus(1, 0, 32'hB, 1, 0);
        @(negedge clk);
        checkOutput("pop+accept before", out0_data, 32'hA);
        checkOutput("pop+accept in_ready", {31'd0, in_ready}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("pop+accept out0_data", out0_data, 32'hB);
        checkOutput("pop+accept out0_valid", {31'd0, out0_valid}, 32'd1);

        // Asynchronous reset in the middle of a transfer.
        applyStimulus(1, 1, 32'h77, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("async reset out0_valid", {31'd0, out0_valid}, 32'd0);
        checkOutput("async reset out1_valid", {31'd0, out1_valid}, 32'd0);
        checkOutput("async reset out0_data", out0_data, 32'd0);
        checkOutput("async reset out1_data", out1_data, 32'd0);
        applyStimulus(0, 1, 0, 0, 0);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("after reset in_ready", {31'd0, in_ready}, 32'd1);

        // Mixed traffic; the model comparison checks every cycle.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WIDTH'($urandom),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

`ifdef STREAM_DEMUX_CNT_EN
        // Counter wrap: preload cnt0 with all-ones, then pop one beat.
        applyStimulus(1, 0, 32'h1234, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        force dut.cnt0_q = 32'hFFFFFFFF;
        modelCnt0 = 32'hFFFFFFFF;
        #1;
        release dut.cnt0_q;
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("cnt0 wrap", cnt0, 32'd0);
        applyStimulus(0, 1, 0, 0, 0);
        rstn = 1'b0;
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, WIDTH'(i), 1, 1);
        end
        applyStimulus(0, 1, 0, 1, 1);
        applyStimulus(0, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("cnt1 three pops", cnt1, 32'd3);
`endif

        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
